vrf_seq: RTL

VRF_SEQ -- requirements
Module: vrf_seq

---
 rtl/vrf_seq_pkg.sv | 27 ++
 rtl/vrf_lane_alu.sv | 26 ++
 rtl/vrf_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vrf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vrf_seq_pkg
// Purpose : Opcodes, FSM state encoding and helpers for the vector sequencer.
// Revision: 1.0
// ============================================================================
package vrf_seq_pkg;

  localparam logic [2:0] OP_VADD  = 3'b000;
  localparam logic [2:0] OP_VSUB  = 3'b001;
  localparam logic [2:0] OP_VMOV  = 3'b010;
  localparam logic [2:0] OP_VCLR  = 3'b011;
  localparam logic [2:0] OP_VSWAP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_WB2  = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_VSWAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_lane_alu.sv
`default_nettype none
// ============================================================================
// Module  : vrf_lane_alu
// Purpose : Lane-wise 32-bit add/subtract with no carry between lanes.
// Revision: 1.0
// ============================================================================
module vrf_lane_alu #(
  parameter int LANE_W = 8
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);

  localparam int NUM_LANES = 32 / LANE_W;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign y[i*LANE_W +: LANE_W] = sub ? (a[i*LANE_W +: LANE_W] - b[i*LANE_W +: LANE_W])
                                         : (a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vrf_seq.sv
`default_nettype none
// ============================================================================
// Module  : vrf_seq
// Purpose : Multi-cycle vector command sequencer driving a 4-entry register file.
// Revision: 1.0
// ============================================================================
module vrf_seq
  import vrf_seq_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_src1,
  input  logic [1:0]  cmd_src2,
  output logic [1:0]  vreg1,
  output logic [1:0]  vreg2,
  input  logic [31:0] vdata1,
  input  logic [31:0] vdata2,
  output logic [1:0]  vregw,
  output logic [31:0] vdataw,
  output logic        VRFWrite,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  dst_q, dst_d;
  logic [1:0]  src1_q, src1_d;
  logic [1:0]  src2_q, src2_d;
  logic [31:0] res_q, res_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_y;

  vrf_lane_alu #(.LANE_W(LANE_W)) u_alu (
    .a   (vdata1),
    .b   (vdata2),
    .sub (op_q == OP_VSUB),
    .y   (alu_y)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    res_d    = res_q;
    b_d      = b_q;
    vreg1    = 2'd0;
    vreg2    = 2'd0;
    vregw    = 2'd0;
    vdataw   = 32'd0;
    VRFWrite = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src1_d  = cmd_src1;
          src2_d  = cmd_src2;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // VSWAP reads the old dst on port 2 so both halves are captured before any write
        vreg1 = src1_q;
        vreg2 = (op_q == OP_VSWAP) ? dst_q : src2_q;
        if (!op_legal(op_q)) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          b_d = vdata2;
          case (op_q)
            OP_VADD, OP_VSUB: res_d = alu_y;
            OP_VCLR:          res_d = 32'd0;
            default:          res_d = vdata1;
          endcase
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        VRFWrite = 1'b1;
        vregw    = dst_q;
        vdataw   = res_q;
        if (op_q == OP_VSWAP) begin
          state_d = ST_WB2;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB2: begin
        VRFWrite = 1'b1;
        vregw    = src1_q;
        vdataw   = b_q;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset landing mid-command must not commit a write or report retirement
    if (reset) begin
      VRFWrite = 1'b0;
      vregw    = 2'd0;
      vdataw   = 32'd0;
      done     = 1'b0;
      err      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      dst_q   <= 2'd0;
      src1_q  <= 2'd0;
      src2_q  <= 2'd0;
      res_q   <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      res_q   <= res_d;
      b_q     <= b_d;
    end
  end

endmodule
`default_nettype wire
